// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared constants and state encoding for the fetch-stage PC
//            sequencer (pc_sequencer / pc_next_sel).
// Contents : c_ADDR_W, c_PC_INC, c_RESET_VEC, c_TRAP_VEC defaults;
//            state_t (ST_IDLE, ST_FETCH, ST_HALT).
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int          c_ADDR_W    = 32;
    localparam int          c_PC_INC    = 4;
    localparam logic [31:0] c_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] c_TRAP_VEC  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_sel
// Purpose  : Combinational next-PC selector: hold, sequential increment,
//            redirect to an aligned target, or trap vector on a misaligned
//            redirect (only when PC_MISALIGN_TRAP_EN is defined).
// Ports    : pc        - current PC
//            redirect  - take target this cycle (highest priority)
//            advance   - step pc by PC_INC
//            target    - redirect address
//            pc_next   - selected next PC
//            trap_take - redirect was misaligned and went to TRAP_VEC
// Config   : PC_MISALIGN_TRAP_EN - misaligned redirect loads TRAP_VEC;
//            otherwise the low two target bits are cleared.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                PC_INC   = c_PC_INC
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(c_TRAP_VEC)
`endif
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    input  logic              advance,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc_next,
    output logic              trap_take
);

    always_comb begin
        pc_next   = pc;
        trap_take = 1'b0;
        if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
                pc_next   = TRAP_VEC;
                trap_take = 1'b1;
            end else begin
                pc_next   = target;
            end
`else
            // Misaligned targets are silently word-aligned.
            pc_next = target & ~ADDR_W'(3);
`endif
        end else if (advance) begin
            // Natural wrap modulo 2^ADDR_W, no overflow indication.
            pc_next = pc + ADDR_W'(PC_INC);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-stage controller. Owns the PC, issues req/ack fetches to
//            instruction memory and holds the fetched word in a one-entry
//            slot for decode. Handles branch redirect (flush) and sticky halt.
// Ports    : clk, rst (sync, active-high)
//            imem_req/imem_addr/imem_ack/imem_rdata - imem fetch handshake
//            stall                  - decode cannot take the slot
//            br_taken/br_target     - single-cycle redirect
//            halt                   - stop fetching until reset
//            fetch_valid/fetch_pc/fetch_instr - slot to decode
//            pc_out, halted, trap   - status
// Config   : PC_MISALIGN_TRAP_EN - misaligned redirect loads TRAP_VEC and
//            pulses trap; when undefined trap stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W    = c_ADDR_W,
    parameter int                PC_INC    = c_PC_INC,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(c_RESET_VEC)
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(c_TRAP_VEC)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              trap
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [31:0]         r_fetch_instr;
    logic                r_trap;

    logic                w_fetching;
    logic                w_ack_fire;
    logic                w_redirect;
    logic                w_advance;
    logic [ADDR_W-1:0]   w_pc_next;
    logic                w_trap_take;

    // A full slot that decode will not take blocks new requests; otherwise
    // the request stays up (same address) until acked.
    assign w_fetching = (r_state == ST_FETCH);
    assign imem_req   = w_fetching && !(r_valid && stall);
    assign imem_addr  = r_pc;
    assign w_ack_fire = imem_req && imem_ack;

    // Priority: halt > redirect > ack. Halt simply holds the PC.
    assign w_redirect = w_fetching && !halt && br_taken;
    assign w_advance  = w_fetching && !halt && !br_taken && w_ack_fire;

    pc_next_sel #(
        .ADDR_W   (ADDR_W),
        .PC_INC   (PC_INC)
`ifdef PC_MISALIGN_TRAP_EN
      , .TRAP_VEC (TRAP_VEC)
`endif
    ) u_pc_next_sel (
        .pc        (r_pc),
        .redirect  (w_redirect),
        .advance   (w_advance),
        .target    (br_target),
        .pc_next   (w_pc_next),
        .trap_take (w_trap_take)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_VEC;
            r_valid       <= 1'b0;
            r_fetch_pc    <= '0;
            r_fetch_instr <= '0;
            r_trap        <= 1'b0;
        end else begin
            r_trap <= 1'b0;
            r_pc   <= w_pc_next;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (halt) begin
                        r_state <= ST_HALT;
                        r_valid <= 1'b0;
                    end else if (br_taken) begin
                        // Flush; any same-cycle ack is dropped.
                        r_valid <= 1'b0;
                        r_trap  <= w_trap_take;
                    end else if (w_ack_fire) begin
                        // Covers both fill-empty and drain-and-refill.
                        r_valid       <= 1'b1;
                        r_fetch_pc    <= r_pc;
                        r_fetch_instr <= imem_rdata;
                    end else if (r_valid && !stall) begin
                        r_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fetch_valid = r_valid;
    assign fetch_pc    = r_fetch_pc;
    assign fetch_instr = r_fetch_instr;
    assign pc_out      = r_pc;
    assign halted      = (r_state == ST_HALT);
    assign trap        = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. A cycle-level reference
//            model (plain variables and arithmetic) tracks PC, slot and
//            halt/run status; directed scenarios plus a random run compare
//            DUT outputs against it and against fixed expected constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        halt = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic [31:0] pc_out;
    logic        halted;
    logic        trap;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt        (halt),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .pc_out      (pc_out),
        .halted      (halted),
        .trap        (trap)
    );

    // Reference model state
    bit          m_started;
    bit          m_halted;
    bit          m_valid;
    bit          m_trap;
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    logic [31:0] m_finstr;

    function automatic bit m_req();
        return m_started && !m_halted && !(m_valid && stall);
    endfunction

    task automatic drive(input logic r, input logic a, input logic s,
                         input logic b, input logic h,
                         input logic [31:0] t, input logic [31:0] d);
        @(negedge clk);
        rst = r; imem_ack = a; stall = s; br_taken = b; halt = h;
        br_target = t; imem_rdata = d;
        #1;
    endtask

    // Advance model and DUT by one rising edge using the currently driven inputs.
    task automatic tick();
        bit          n_started = m_started;
        bit          n_halted  = m_halted;
        bit          n_valid   = m_valid;
        bit          n_trap    = 1'b0;
        logic [31:0] n_pc      = m_pc;
        logic [31:0] n_fpc     = m_fpc;
        logic [31:0] n_finstr  = m_finstr;
        if (rst) begin
            n_started = 0; n_halted = 0; n_valid = 0;
            n_pc = 32'h0; n_fpc = 32'h0; n_finstr = 32'h0;
        end else if (!m_started) begin
            n_started = 1;
        end else if (!m_halted) begin
            if (halt) begin
                n_halted = 1; n_valid = 0;
            end else if (br_taken) begin
                n_valid = 0;
`ifdef PC_MISALIGN_TRAP_EN
                if (br_target % 4 != 0) begin
                    n_pc = 32'h100; n_trap = 1;
                end else begin
                    n_pc = br_target;
                end
`else
                n_pc = br_target - (br_target % 4);
`endif
            end else if (m_req() && imem_ack) begin
                n_fpc = m_pc; n_finstr = imem_rdata; n_valid = 1;
                n_pc = m_pc + 32'd4;
            end else if (m_valid && !stall) begin
                n_valid = 0;
            end
        end
        @(posedge clk);
        m_started = n_started; m_halted = n_halted; m_valid = n_valid;
        m_trap = n_trap; m_pc = n_pc; m_fpc = n_fpc; m_finstr = n_finstr;
    endtask

    // Reset 3 cycles, pass the idle cycle, then take n acks back-to-back.
    task automatic start(input int n_acks);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < n_acks; i++) begin
            drive(0, 1, 0, 0, 0, 0, $urandom); tick();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 1, 32'h44, $urandom); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=%h", pc_out, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_c1 got=%b want=0", imem_req); end
        total++; if ({fetch_valid, halted, trap} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {fetch_valid, halted, trap}); end
        total++; if ({fetch_pc, fetch_instr} !== 64'h0) begin bad++; $display("FAIL rst_slot got=%h want=0", {fetch_pc, fetch_instr}); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_req_c2 got=%b/%h want=1/0", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] prev_d = '0;
        logic [31:0] d;
        start(0);
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            drive(0, 1, 0, 0, 0, 0, d);
            total++; if (imem_addr !== 32'(4 * k)) begin bad++; $display("FAIL seq_addr got=%h want=%h", imem_addr, 32'(4 * k)); end
            if (k >= 1) begin
                total++;
                if (fetch_valid !== 1'b1 || fetch_pc !== 32'(4 * (k - 1)) || fetch_instr !== prev_d) begin
                    bad++; $display("FAIL seq_slot got=%b/%h/%h want=1/%h/%h", fetch_valid, fetch_pc, fetch_instr, 32'(4 * (k - 1)), prev_d);
                end
            end
            prev_d = d;
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        start(2);
        held_pc = fetch_pc; held_instr = m_finstr;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 0, $urandom);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b want=0", imem_req); end
            total++;
            if (fetch_valid !== 1'b1 || fetch_pc !== 32'h4 || fetch_instr !== held_instr) begin
                bad++; $display("FAIL stall_slot got=%b/%h/%h want=1/%h/%h", fetch_valid, fetch_pc, fetch_instr, 32'h4, held_instr);
            end
            tick();
        end
        drive(0, 1, 0, 0, 0, 0, 32'hCAFE_0008);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL stall_resume got=%b/%h want=1/8 (held %h)", imem_req, imem_addr, held_pc); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (fetch_pc !== 32'h8 || fetch_instr !== 32'hCAFE_0008) begin bad++; $display("FAIL stall_next got=%h/%h want=8/cafe0008", fetch_pc, fetch_instr); end
        tick();
    endtask

    task automatic test_branch();
        start(2);
        drive(0, 1, 0, 1, 0, 32'h40, $urandom);
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL br_pre_addr got=%h want=8", imem_addr); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL br_flush got=%b want=0", fetch_valid); end
        total++; if (imem_addr !== 32'h40 || pc_out !== 32'h40) begin bad++; $display("FAIL br_addr got=%h/%h want=40/40", imem_addr, pc_out); end
        tick();
    endtask

    task automatic test_wrap_halt();
        start(0);
        drive(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 32'h1234_5678);
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h want=fffffffc", imem_addr); end
        tick();
        drive(0, 1, 0, 1, 1, 32'h80, $urandom);
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=0", pc_out); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 1, 0, 32'h80, $urandom);
            total++;
            if (halted !== 1'b1 || pc_out !== 32'h0 || imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
                bad++; $display("FAIL halt_state got=%b/%h/%b/%b want=1/0/0/0", halted, pc_out, imem_req, fetch_valid);
            end
            tick();
        end
    endtask

    task automatic test_misalign();
        start(0);
        drive(0, 0, 0, 1, 0, 32'h42, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
        total++; if (pc_out !== 32'h100 || trap !== 1'b1) begin bad++; $display("FAIL mis_redirect got=%h/%b want=100/1", pc_out, trap); end
`else
        total++; if (pc_out !== 32'h40 || trap !== 1'b0) begin bad++; $display("FAIL mis_redirect got=%h/%b want=40/0", pc_out, trap); end
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL mis_trap_pulse got=%b want=0", trap); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] t;
        start(0);
        for (int i = 0; i < 600; i++) begin
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 79) == 0, t, $urandom);
            total++;
            if (imem_req !== m_req() || imem_addr !== m_pc || pc_out !== m_pc) begin
                bad++; $display("FAIL rnd_req i=%0d got=%b/%h/%h want=%b/%h", i, imem_req, imem_addr, pc_out, m_req(), m_pc);
            end
            total++;
            if (fetch_valid !== m_valid || halted !== m_halted || trap !== m_trap) begin
                bad++; $display("FAIL rnd_flags i=%0d got=%b%b%b want=%b%b%b", i, fetch_valid, halted, trap, m_valid, m_halted, m_trap);
            end
            if (m_valid) begin
                total++;
                if (fetch_pc !== m_fpc || fetch_instr !== m_finstr) begin
                    bad++; $display("FAIL rnd_slot i=%0d got=%h/%h want=%h/%h", i, fetch_pc, fetch_instr, m_fpc, m_finstr);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_wrap_halt();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
